// File: rtl/serial_tx_control.sv
// Transmit sequencer for a UART-style serial port.
// Walks a frame through load, optional start bit, data shifting, optional
// stop bit and TI handshake, pacing every bit on rising edges of the
// baud-rate square wave. All outputs are registered from the next state.
//
// Handshake: serial_serial_tx_i is a request pulse accepted only in IDLE
// with TI clear. Once accepted, the frame runs to DONE. In DONE, TI is
// requested until software reflects TI=1 back on serial_scon1_ti_i. No
// backpressure exists on any other signal.
module serial_tx_control (
    input  logic serial_clock_i,
    input  logic serial_reset_i,
    input  logic serial_br_i,
    input  logic serial_scon7_sm0_i,
    input  logic serial_scon1_ti_i,
    input  logic serial_end_bit_i,
    input  logic serial_serial_tx_i,
    output logic serial_p3en_0_o,
    output logic serial_p3en_1_o,
    output logic serial_data_en_o,
    output logic serial_scon1_ti_o,
    output logic serial_send_o,
    output logic serial_shift_o,
    output logic serial_stop_bit_gen_o,
    output logic serial_start_shifter_reg_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_br;
    logic   w_tick;
    logic   w_shift;

    logic   r_p3en_0;
    logic   r_p3en_1;
    logic   r_data_en;
    logic   r_ti;
    logic   r_send;
    logic   r_shift;
    logic   r_stop_bit;
    logic   r_start_shifter;

    // Baud wave sampled once; its previous value gives the edge reference.
    always_ff @(posedge serial_clock_i or posedge serial_reset_i) begin
        if (serial_reset_i) begin
            r_br <= 1'b0;
        end else begin
            r_br <= serial_br_i;
        end
    end

    // One-clock tick on the clock in which the registered baud value goes 0 -> 1.
    assign w_tick = serial_br_i & ~r_br;

    // State register.
    always_ff @(posedge serial_clock_i or posedge serial_reset_i) begin
        if (serial_reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and the shift request for the coming clock.
    always_comb begin
        w_next  = r_state;
        w_shift = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (serial_serial_tx_i && !serial_scon1_ti_i) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                // A tick landing on the load clock is deliberately dropped.
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_tick) begin
                    w_next = serial_scon7_sm0_i ? S_START : S_DATA;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (serial_end_bit_i) begin
                        w_next = serial_scon7_sm0_i ? S_STOP : S_DONE;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (serial_scon1_ti_i) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs registered from the next state so they line up with state entry.
    always_ff @(posedge serial_clock_i or posedge serial_reset_i) begin
        if (serial_reset_i) begin
            r_p3en_0        <= 1'b0;
            r_p3en_1        <= 1'b0;
            r_data_en       <= 1'b0;
            r_ti            <= 1'b0;
            r_send          <= 1'b0;
            r_shift         <= 1'b0;
            r_stop_bit      <= 1'b0;
            r_start_shifter <= 1'b0;
        end else begin
            r_p3en_1        <= (w_next != S_IDLE);
            r_p3en_0        <= (w_next != S_IDLE) && !serial_scon7_sm0_i;
            r_data_en       <= (w_next == S_DATA);
            r_ti            <= (w_next == S_DONE);
            r_send          <= (w_next == S_START) || (w_next == S_DATA) ||
                               (w_next == S_STOP);
            r_shift         <= w_shift;
            r_stop_bit      <= (w_next == S_STOP);
            r_start_shifter <= (w_next == S_LOAD);
        end
    end

    assign serial_p3en_0_o            = r_p3en_0;
    assign serial_p3en_1_o            = r_p3en_1;
    assign serial_data_en_o           = r_data_en;
    assign serial_scon1_ti_o          = r_ti;
    assign serial_send_o              = r_send;
    assign serial_shift_o             = r_shift;
    assign serial_stop_bit_gen_o      = r_stop_bit;
    assign serial_start_shifter_reg_o = r_start_shifter;

endmodule

// File: tb/tb_serial_tx_control.sv
// Directed bench for serial_tx_control. Every change of the output vector
// is compared against an expected sequence queued when a frame is launched.
module tb_serial_tx_control;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic br = 1'b0;
  logic sm0 = 1'b0;
  logic ti_i = 1'b0;
  logic end_bit = 1'b0;
  logic tx = 1'b0;

  logic p3en_0, p3en_1, data_en, ti_o, send, shift, stop_bit, start_sh;
  logic [7:0] outv;
  assign outv = {p3en_0, p3en_1, data_en, ti_o, send, shift, stop_bit, start_sh};

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  int ph = 0;
  logic [7:0] prev_v = 8'h00;
  int cyc = 0;
  int last_chg = 0;
  int last_shift = 0;
  int shift_cnt = 0;
  bit mon_en = 1'b0;

  localparam logic [7:0] V_START = 8'b0100_1000;
  localparam logic [7:0] V_STOP  = 8'b0100_1010;

  serial_tx_control dut (
    .serial_clock_i             (clk),
    .serial_reset_i             (rst),
    .serial_br_i                (br),
    .serial_scon7_sm0_i         (sm0),
    .serial_scon1_ti_i          (ti_i),
    .serial_end_bit_i           (end_bit),
    .serial_serial_tx_i         (tx),
    .serial_p3en_0_o            (p3en_0),
    .serial_p3en_1_o            (p3en_1),
    .serial_data_en_o           (data_en),
    .serial_scon1_ti_o          (ti_o),
    .serial_send_o              (send),
    .serial_shift_o             (shift),
    .serial_stop_bit_gen_o      (stop_bit),
    .serial_start_shifter_reg_o (start_sh)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // baud wave: 32-clock period, rises when ph becomes 16
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 32;
      br = (ph >= 16);
    end
  end

  function automatic logic [7:0] vec(input logic a, input logic b, input logic c,
                                     input logic d, input logic e, input logic f,
                                     input logic g, input logic h);
    return {a, b, c, d, e, f, g, h};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard monitor: each output change pops one expected vector
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (outv !== prev_v) begin
        if (mon_en) begin
          chk_int("unexpected_change", (exp_q.size() != 0) ? 1 : 0, 1);
          if (exp_q.size() != 0) chk("sequence", outv, exp_q.pop_front());
          if (prev_v == V_START || prev_v == V_STOP) chk_int("bit_time", cyc - last_chg, 32);
          if (outv[2] && !prev_v[2]) begin
            shift_cnt++;
            if (shift_cnt > 1) chk_int("shift_spacing", cyc - last_shift, 32);
            last_shift = cyc;
          end
        end
        last_chg = cyc;
        prev_v = outv;
      end
    end
  end

  // expected output sequence of one complete frame
  task automatic push_frame(input logic mode);
    logic p0;
    p0 = ~mode;
    exp_q.push_back(vec(p0, 1, 0, 0, 0, 0, 0, 1));  // LOAD
    exp_q.push_back(vec(p0, 1, 0, 0, 0, 0, 0, 0));  // WAIT
    if (mode) exp_q.push_back(V_START);
    exp_q.push_back(vec(p0, 1, 1, 0, 1, 0, 0, 0));  // DATA
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vec(p0, 1, 1, 0, 1, 1, 0, 0));
      exp_q.push_back(vec(p0, 1, 1, 0, 1, 0, 0, 0));
    end
    if (mode) exp_q.push_back(V_STOP);
    exp_q.push_back(vec(p0, 1, 0, 1, 0, 0, 0, 0));  // DONE
    exp_q.push_back(8'h00);                         // IDLE
  endtask

  task automatic pulse_tx();
    tx = 1'b1;
    @(posedge clk);
    #2;
    tx = 1'b0;
  endtask

  task automatic run_frame(input logic mode, input bit align_load, input bit extra_tx);
    int n;
    sm0 = mode;
    end_bit = 1'b0;
    shift_cnt = 0;
    push_frame(mode);
    n = 0;
    @(posedge clk);
    #2;
    // place the load clock on top of a tick when requested
    while (align_load && ph != 15 && n < 64) begin
      @(posedge clk);
      #2;
      n++;
    end
    pulse_tx();
    if (extra_tx) begin
      n = 0;
      while (shift_cnt < 4 && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk_int("wait_shift4", (shift_cnt >= 4) ? 1 : 0, 1);
      @(posedge clk);
      #2;
      pulse_tx();
    end
    n = 0;
    while (shift_cnt < 8 && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk_int("wait_shift8", (shift_cnt >= 8) ? 1 : 0, 1);
    end_bit = 1'b1;
    n = 0;
    while (ti_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_int("wait_ti", (ti_o === 1'b1) ? 1 : 0, 1);
    end_bit = 1'b0;
    repeat (3) @(negedge clk);
    chk("ti_held", outv, vec(~mode, 1, 0, 1, 0, 0, 0, 0));
    ti_i = 1'b1;
    n = 0;
    while (outv !== 8'h00 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("back_to_idle", outv, 8'h00);
    ti_i = 1'b0;
    repeat (4) @(negedge clk);
    chk_int("shift_count", shift_cnt, 8);
    chk_int("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    // reset held two clocks
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", outv, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset", outv, 8'h00);
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_persist", outv, 8'h00);

    // mode 2 frame, then mode 0 frame
    run_frame(1'b1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0);

    // request while TI is set is ignored
    ti_i = 1'b1;
    @(posedge clk);
    #2;
    pulse_tx();
    repeat (40) @(negedge clk);
    chk("ti_blocks_request", outv, 8'h00);
    ti_i = 1'b0;
    @(negedge clk);

    // reset pulsed in the middle of DATA
    sm0 = 1'b1;
    shift_cnt = 0;
    push_frame(1'b1);
    @(posedge clk);
    #2;
    pulse_tx();
    n = 0;
    while (shift_cnt < 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk_int("wait_shift3", (shift_cnt >= 3) ? 1 : 0, 1);
    chk("data_before_reset", outv & 8'b0110_1000, 8'b0110_1000);
    mon_en = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_abort", outv, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("after_abort", outv, 8'h00);
    exp_q.delete();
    mon_en = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_ti_after_abort", outv, 8'h00);

    // clean frame: load coincides with a tick, second request during DATA
    run_frame(1'b1, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
